// File: rtl/ssc_pkg.sv
// Shared types and constants for the staged select controller.
package ssc_pkg;

    localparam int SSC_STATE_W = 2;

    // Encoding is visible on the state output, so the values are fixed.
    typedef enum logic [SSC_STATE_W-1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SERVE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/ssc_if.sv
// Front-panel side bundle of the staged select controller.
//
// Signalling contract: there is no valid/ready handshake on this bundle.
// sel and cancel are level inputs sampled on every rising clk edge.
// done and timeout are single-cycle strobes; result is meaningful in the
// cycle done is high and is held afterwards until the next capture or abort.
interface ssc_if
    import ssc_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = 2
);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES*SEL_W-1:0] sel;
    logic                        cancel;
    logic [SSC_STATE_W-1:0]      state;
    logic [IDX_W-1:0]            stage_idx;
    logic [NUM_STAGES*SEL_W-1:0] result;
    logic                        done;
    logic                        timeout;

    // Select decoders drive the request side.
    modport master (
        output sel, cancel,
        input  state, stage_idx, result, done, timeout
    );

    // The controller consumes selects and reports progress.
    modport slave (
        input  sel, cancel,
        output state, stage_idx, result, done, timeout
    );

endinterface

// File: rtl/ssc_down_timer.sv
// Loadable down counter; expired is high while the count sits at zero.
module ssc_down_timer #(
    parameter int CNT_W    = 4,
    parameter int LOAD_VAL = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over counting; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/staged_select_controller.sv
// Sequences ordered select stages, captures each non-zero code, holds a
// fixed SERVE interval and then strobes done with the captured codes.
module staged_select_controller
    import ssc_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = 2,
    parameter int TIMEOUT    = 8,
    parameter int SERVE_CYC  = 4
) (
    input  logic clk,
    input  logic rst,
    ssc_if.slave bus
);

    localparam int               IDX_W    = $clog2(NUM_STAGES + 1);
    localparam int               BUS_W    = NUM_STAGES * SEL_W;
    localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
    localparam int               SERVE_W  = $clog2(SERVE_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] stage_idx_q, stage_idx_d;
    logic [BUS_W-1:0] result_q,    result_d;
    logic             done_q,      done_d;
    logic             timeout_q,   timeout_d;
    logic             armed_q,     armed_d;

    logic [SEL_W-1:0] sel0;
    logic [SEL_W-1:0] cur_code;
    logic             idle_load, idle_en, idle_expired;
    logic             serve_load, serve_en, serve_expired;

    assign sel0 = bus.sel[SEL_W-1:0];

    // Code presented by the stage currently awaited; later stages are not looked at.
    always_comb begin
        cur_code = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (stage_idx_q == IDX_W'(k)) begin
                cur_code = bus.sel[k*SEL_W +: SEL_W];
            end
        end
    end

    // Inactivity window while waiting for the next stage.
    ssc_down_timer #(
        .CNT_W    (IDLE_W),
        .LOAD_VAL (TIMEOUT - 1)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (idle_load),
        .enable_i  (idle_en),
        .expired_o (idle_expired)
    );

    // Fixed service interval.
    ssc_down_timer #(
        .CNT_W    (SERVE_W),
        .LOAD_VAL (SERVE_CYC - 1)
    ) u_serve_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (serve_load),
        .enable_i  (serve_en),
        .expired_o (serve_expired)
    );

    // Next-state, capture and strobe decisions for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        result_d    = result_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        armed_d     = armed_q;
        idle_load   = 1'b0;
        idle_en     = 1'b0;
        serve_load  = 1'b0;
        serve_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A stage-0 code only starts a transaction after a zero has been seen,
                // so a code held from the previous transaction cannot retrigger.
                if (armed_q && (sel0 != '0)) begin
                    result_d              = '0;
                    result_d[SEL_W-1:0]   = sel0;
                    stage_idx_d           = IDX_W'(1);
                    armed_d               = 1'b0;
                    if (NUM_STAGES == 1) begin
                        state_d    = SERVE;
                        serve_load = 1'b1;
                    end else begin
                        state_d   = COLLECT;
                        idle_load = 1'b1;
                    end
                end else if (sel0 == '0) begin
                    armed_d = 1'b1;
                end
            end

            COLLECT: begin
                if (bus.cancel) begin
                    state_d     = IDLE;
                    stage_idx_d = '0;
                    result_d    = '0;
                end else if (cur_code != '0) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (stage_idx_q == IDX_W'(k)) begin
                            result_d[k*SEL_W +: SEL_W] = cur_code;
                        end
                    end
                    stage_idx_d = stage_idx_q + IDX_W'(1);
                    if (stage_idx_q == LAST_IDX) begin
                        state_d    = SERVE;
                        serve_load = 1'b1;
                    end else begin
                        idle_load = 1'b1;
                    end
                end else if (idle_expired) begin
                    state_d     = IDLE;
                    stage_idx_d = '0;
                    result_d    = '0;
                    timeout_d   = 1'b1;
                end else begin
                    idle_en = 1'b1;
                end
            end

            SERVE: begin
                if (serve_expired) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    serve_en = 1'b1;
                end
            end

            DONE: begin
                state_d     = IDLE;
                stage_idx_d = '0;
            end
        endcase
    end

    // FSM and output registers; reset clears everything including pending strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_idx_q <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_idx_q <= stage_idx_d;
            result_q    <= result_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            armed_q     <= armed_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.stage_idx = stage_idx_q;
    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_staged_select_controller.sv
// Bench for staged_select_controller: table of normal-flow vectors, directed
// corner sequences, randomized traffic against a behavioural model, and a
// second instance with minimal parameters.
module tb_staged_select_controller;

    localparam int A_NS      = 3;
    localparam int A_TIMEOUT = 8;
    localparam int A_SERVE   = 4;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int checks = 0;
    int errors = 0;
    string cur_tag = "init";

    ssc_if #(.NUM_STAGES(3), .SEL_W(2)) if_a ();
    ssc_if #(.NUM_STAGES(1), .SEL_W(2)) if_b ();

    staged_select_controller #(
        .NUM_STAGES (3),
        .SEL_W      (2),
        .TIMEOUT    (8),
        .SERVE_CYC  (4)
    ) dut (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a)
    );

    staged_select_controller #(
        .NUM_STAGES (1),
        .SEL_W      (2),
        .TIMEOUT    (1),
        .SERVE_CYC  (1)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b)
    );

    // 20 time-unit period clock
    always #10 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", cur_tag, name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model for instance A ----------------
    int   m_phase;
    int   m_pos;
    int   m_idle;
    int   m_serve;
    int   m_codes[A_NS];
    bit   m_armed;
    bit   m_done;
    bit   m_to;

    function automatic logic [5:0] m_result();
        logic [5:0] r;
        int c;
        r = '0;
        for (int k = 0; k < A_NS; k++) begin
            c = m_codes[k];
            r[k*2 +: 2] = c[1:0];
        end
        return r;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < A_NS; k++) m_codes[k] = 0;
    endtask

    task automatic model_step(input logic r, input logic [5:0] s, input logic c);
        int code[A_NS];
        for (int k = 0; k < A_NS; k++) code[k] = int'(s[k*2 +: 2]);
        m_done = 0;
        m_to   = 0;
        if (r) begin
            m_phase = 0; m_pos = 0; m_idle = 0; m_serve = 0; m_armed = 0;
            m_clear();
        end else begin
            case (m_phase)
                0: begin
                    if (m_armed && code[0] != 0) begin
                        m_clear();
                        m_codes[0] = code[0];
                        m_pos   = 1;
                        m_armed = 0;
                        m_phase = 1;
                        m_idle  = 0;
                    end else if (code[0] == 0) begin
                        m_armed = 1;
                    end
                end
                1: begin
                    if (c) begin
                        m_phase = 0; m_pos = 0;
                        m_clear();
                    end else if (code[m_pos] != 0) begin
                        m_codes[m_pos] = code[m_pos];
                        m_pos++;
                        m_idle = 0;
                        if (m_pos == A_NS) begin
                            m_phase = 2;
                            m_serve = 0;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == A_TIMEOUT) begin
                            m_phase = 0; m_pos = 0; m_idle = 0; m_to = 1;
                            m_clear();
                        end
                    end
                end
                2: begin
                    m_serve++;
                    if (m_serve == A_SERVE) begin
                        m_phase = 3;
                        m_done  = 1;
                    end
                end
                default: begin
                    m_phase = 0;
                    m_pos   = 0;
                end
            endcase
        end
    endtask

    task automatic compare_a();
        chk("state",     32'(if_a.state),     32'(m_phase));
        chk("stage_idx", 32'(if_a.stage_idx), 32'(m_pos));
        chk("result",    32'(if_a.result),    32'(m_result()));
        chk("done",      32'(if_a.done),      32'(m_done));
        chk("timeout",   32'(if_a.timeout),   32'(m_to));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic cyc(input logic r, input logic [5:0] s, input logic c);
        rst_a       = r;
        if_a.sel    = s;
        if_a.cancel = c;
        @(posedge clk);
        model_step(r, s, c);
        @(negedge clk);
        compare_a();
    endtask

    function automatic logic [5:0] mk(input logic [1:0] s2, input logic [1:0] s1, input logic [1:0] s0);
        return {s2, s1, s0};
    endfunction

    // Instance B driven at a falling edge and checked against hand-derived values.
    task automatic cyc_b(input string tag, input logic r, input logic [1:0] s,
                         input logic [1:0] e_st, input logic e_idx, input logic [1:0] e_res,
                         input logic e_done);
        cur_tag     = tag;
        rst_b       = r;
        if_b.sel    = s;
        if_b.cancel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b_state",     32'(if_b.state),     32'(e_st));
        chk("b_stage_idx", 32'(if_b.stage_idx), 32'(e_idx));
        chk("b_result",    32'(if_b.result),    32'(e_res));
        chk("b_done",      32'(if_b.done),      32'(e_done));
        chk("b_timeout",   32'(if_b.timeout),   32'(0));
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] sel;
        logic       cancel;
        logic [1:0] st;
        logic [1:0] idx;
        logic [5:0] res;
        logic       done;
        logic       to;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n_col;
        int n_to;
        int n_done;
        int dens;
        logic [5:0] rs;
        logic rr;
        logic rc;

        // Normal flow: expected outputs after each edge
        tbl[0]  = '{1'b1, 6'b000000, 1'b0, 2'd0, 2'd0, 6'b000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 6'b000000, 1'b0, 2'd0, 2'd0, 6'b000000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 6'b000000, 1'b0, 2'd0, 2'd0, 6'b000000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 6'b000001, 1'b0, 2'd1, 2'd1, 6'b000001, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 6'b000100, 1'b0, 2'd1, 2'd2, 6'b000101, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 6'b010000, 1'b0, 2'd2, 2'd3, 6'b010101, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 6'b000000, 1'b0, 2'd2, 2'd3, 6'b010101, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 6'b000000, 1'b0, 2'd2, 2'd3, 6'b010101, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 6'b000000, 1'b0, 2'd2, 2'd3, 6'b010101, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 6'b000000, 1'b0, 2'd3, 2'd3, 6'b010101, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 6'b000000, 1'b0, 2'd0, 2'd0, 6'b010101, 1'b0, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1;
        if_a.sel = '0; if_a.cancel = 1'b0;
        if_b.sel = '0; if_b.cancel = 1'b0;
        m_phase = 0; m_pos = 0; m_idle = 0; m_serve = 0; m_armed = 0; m_done = 0; m_to = 0;
        m_clear();
        @(negedge clk);

        // ---- instance B: one stage, one-cycle serve ----
        cyc_b("b_reset",   1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        cyc_b("b_reset",   1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        cyc_b("b_arm",     1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        cyc_b("b_start",   1'b0, 2'd3, 2'd2, 1'b1, 2'd3, 1'b0);
        cyc_b("b_done",    1'b0, 2'd3, 2'd3, 1'b1, 2'd3, 1'b1);
        cyc_b("b_idle",    1'b0, 2'd3, 2'd0, 1'b0, 2'd3, 1'b0);
        cyc_b("b_held",    1'b0, 2'd3, 2'd0, 1'b0, 2'd3, 1'b0);
        cyc_b("b_rearm",   1'b0, 2'd0, 2'd0, 1'b0, 2'd3, 1'b0);
        cyc_b("b_start2",  1'b0, 2'd2, 2'd2, 1'b1, 2'd2, 1'b0);
        cyc_b("b_midrst",  1'b1, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
        cyc_b("b_noarm",   1'b0, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
        rst_b = 1'b1;

        // ---- instance A: table-driven normal flow ----
        cur_tag = "normal";
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, tbl[i].sel, tbl[i].cancel);
            chk($sformatf("tbl%0d_state", i),  32'(if_a.state),     32'(tbl[i].st));
            chk($sformatf("tbl%0d_idx", i),    32'(if_a.stage_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d_result", i), 32'(if_a.result),    32'(tbl[i].res));
            chk($sformatf("tbl%0d_done", i),   32'(if_a.done),      32'(tbl[i].done));
            chk($sformatf("tbl%0d_to", i),     32'(if_a.timeout),   32'(tbl[i].to));
        end

        // ---- timeout ----
        cur_tag = "timeout";
        cyc(1'b0, 6'd0, 1'b0);
        cyc(1'b0, mk(2'd0, 2'd0, 2'd2), 1'b0);
        n_col = (if_a.state == 2'd1) ? 1 : 0;
        n_to  = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 6'd0, 1'b0);
            if (if_a.state == 2'd1) n_col++;
            if (if_a.timeout) n_to++;
        end
        chk("collect_cycles", 32'(n_col), 32'(8));
        chk("pulses",         32'(n_to),  32'(1));
        chk("final_state",    32'(if_a.state),  32'(0));
        chk("final_result",   32'(if_a.result), 32'(0));

        // ---- cancel in COLLECT, then cancel ignored in SERVE ----
        cur_tag = "cancel";
        cyc(1'b0, 6'd0, 1'b0);
        cyc(1'b0, mk(2'd0, 2'd0, 2'd1), 1'b0);
        cyc(1'b0, mk(2'd0, 2'd1, 2'd0), 1'b0);
        chk("idx_before", 32'(if_a.stage_idx), 32'(2));
        cyc(1'b0, 6'd0, 1'b1);
        chk("state_after", 32'(if_a.state),  32'(0));
        chk("result_after", 32'(if_a.result), 32'(0));
        chk("no_pulse", 32'({if_a.done, if_a.timeout}), 32'(0));
        cyc(1'b0, 6'd0, 1'b0);
        cyc(1'b0, mk(2'd0, 2'd0, 2'd1), 1'b0);
        cyc(1'b0, mk(2'd0, 2'd1, 2'd0), 1'b0);
        cyc(1'b0, mk(2'd1, 2'd0, 2'd0), 1'b0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 6'd0, 1'b1);
            if (if_a.done) n_done++;
        end
        chk("serve_done_count", 32'(n_done), 32'(1));

        // ---- re-arm gating with stage 0 held ----
        cur_tag = "rearm";
        cyc(1'b0, mk(2'd0, 2'd0, 2'd1), 1'b0);
        chk("started", 32'(if_a.state), 32'(1));
        cyc(1'b0, mk(2'd0, 2'd1, 2'd1), 1'b0);
        cyc(1'b0, mk(2'd1, 2'd1, 2'd1), 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, mk(2'd1, 2'd1, 2'd1), 1'b0);
        chk("held_idle", 32'(if_a.state), 32'(0));
        cyc(1'b0, mk(2'd1, 2'd1, 2'd0), 1'b0);
        chk("drop_idle", 32'(if_a.state), 32'(0));
        cyc(1'b0, mk(2'd0, 2'd0, 2'd1), 1'b0);
        chk("restart", 32'(if_a.state), 32'(1));

        // ---- later stage presented early is ignored ----
        cur_tag = "order";
        cyc(1'b0, mk(2'd3, 2'd0, 2'd0), 1'b0);
        cyc(1'b0, mk(2'd3, 2'd0, 2'd0), 1'b0);
        chk("idx_held", 32'(if_a.stage_idx), 32'(1));
        chk("stage2_empty", 32'(if_a.result[5:4]), 32'(0));
        cyc(1'b0, mk(2'd3, 2'd2, 2'd0), 1'b0);
        cyc(1'b0, mk(2'd3, 2'd0, 2'd0), 1'b0);
        chk("upper_result", 32'(if_a.result[5:2]), 32'(4'b1110));
        chk("in_serve", 32'(if_a.state), 32'(2));

        // ---- reset in SERVE ----
        cur_tag = "midrst";
        cyc(1'b0, 6'd0, 1'b0);
        cyc(1'b1, 6'd0, 1'b0);
        chk("outputs_zero", 32'({if_a.state, if_a.stage_idx, if_a.result, if_a.done, if_a.timeout}), 32'(0));
        cyc(1'b0, 6'd0, 1'b0);

        // ---- randomized traffic against the model ----
        cur_tag = "random";
        dens = 30;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) dens = int'($urandom_range(2, 7)) * 10;
            rs = '0;
            for (int k = 0; k < A_NS; k++) begin
                if (int'($urandom_range(0, 99)) < dens) rs[k*2 +: 2] = 2'($urandom_range(1, 3));
            end
            rr = ($urandom_range(0, 79) == 0);
            rc = ($urandom_range(0, 11) == 0);
            cyc(rr, rs, rc);
            chk("done_and_timeout", 32'(if_a.done & if_a.timeout), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
